rom_load_arbiter: RTL and testbench
===================================

Name: rom_load_arbiter

Overview:
- Sequences the ioctl ROM download into the core's shared 16-bit program/graphics memory port.
- Shares that port with a runtime read requester during and after the load.
- Packs the ioctl byte stream into little-endian 16-bit words and back-pressures the HPS via ioctl_wait.
- Sits between the top-level ioctl bus and the memory controller inside m72.

Parameters:
- MEM_AW, 24, word-address width of the memory port.
- ROM_INDEX, 8'h00, ioctl_index value accepted for ROM loading.
- BASE_WADDR, 0, word offset added to ioctl_addr[24:1].

Ports:
- clock  in  1  core clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to the HPS.
- rd_req  in  1  runtime read request (level, held until rd_ack).
- rd_addr  in  MEM_AW  runtime read word address.
- rd_data  out  16  read data, valid with rd_ack.
- rd_ack  out  1  one-cycle read completion.
- mem_req  out  1  memory request (level).
- mem_we  out  1  1 = write.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  16  write data.
- mem_be  out  2  byte enables; [0] = low byte (even address).
- mem_ack  in  1  one-cycle completion from the controller.
- mem_rdata  in  16  read data, valid with mem_ack.
- load_busy  out  1  matching download in progress or flush pending.
- load_done  out  1  one-cycle pulse at load completion.
- overrun  out  1  sticky: a byte arrived while ioctl_wait=1.
- checksum  out  16  see Optional Feature.

Behaviour:
- Reset (async assert, sync release): every output is 0, the FSM is IDLE, and the pack and write buffers are empty.
- Active download: ioctl_download=1 and ioctl_index==ROM_INDEX. Strobes outside an active download are ignored.
- Packing:
  - Even-address byte: goes into lo, sets lo_valid, and records waddr = ioctl_addr[24:1] + BASE_WADDR (MEM_AW bits, wraps modulo 2^MEM_AW).
  - Odd-address byte: completes the word. The write buffer gets {byte, lo}, be=2'b11 if lo_valid and the word address matches, otherwise be=2'b10.
  - Even byte arriving while lo_valid=1: the stale lo is first queued as be=2'b01, then the new byte is latched.
- Write buffer: one entry. ioctl_wait=1 from the cycle after the buffer fills until the cycle after its mem_ack.
  - ioctl_wr while ioctl_wait=1: byte dropped, overrun set.
  - overrun clears only on reset or on the rising edge of the next matching download.
- FSM states:
  - IDLE: write buffer full -> WRITE; else rd_req -> READ. A write always wins over a simultaneous read.
  - WRITE: mem_req=1, mem_we=1. On mem_ack -> IDLE; mem_req drops the same cycle the ack is sampled.
  - READ: mem_req=1, mem_we=0, mem_addr=rd_addr latched on entry. On mem_ack -> IDLE; rd_data<=mem_rdata and rd_ack=1 for one cycle.
- Latency: mem_req rises one cycle after the FSM leaves IDLE. Request signals stay stable while mem_req=1.
- Download end (falling edge of ioctl_download while index matches):
  - A lone lo_valid is flushed as be=2'b01.
  - load_done pulses the cycle after the final write ack, or the cycle after the edge if nothing is pending.
  - load_busy falls with load_done.
- Downloads with a non-matching index never stall and never touch memory.
- Reset mid-transaction: mem_req drops immediately. The memory controller is reset by the same reset_n.

Optional Feature:
- Macro: ROM_LOAD_CHECKSUM_EN.
- Defined: checksum is a 16-bit wrapping sum of every accepted byte (zero-extended). Cleared on reset and on each matching download rising edge. Frozen after load_done.
- Undefined: checksum is tied to 16'h0000 and no adder is built.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 at addresses 0..3, mem_ack 2 cycles after mem_req -> writes (addr 0, 16'h2211, be=11) then (addr 1, 16'h4433, be=11); load_done one pulse after the last ack; checksum=16'h00AA when enabled.
- Single byte 0x5A at address 7 then download falls -> write (addr 3, 16'h5A00, be=10); byte at address 4 alone -> be=01, data low=byte.
- Second byte strobed while ioctl_wait=1 (mem_ack withheld 10 cycles) -> byte dropped, overrun=1, and only the first word is written.
- rd_req at addr 0x123 in the same cycle a write buffer fills -> write issued first, then read; rd_ack one cycle with rd_data=mem_rdata.
- Download with ioctl_index=8'h01 (ROM_INDEX=0) -> no mem_req, ioctl_wait=0, load_busy=0.
- reset_n pulsed low during WRITE with mem_req=1 -> mem_req, ioctl_wait, and load_busy go to 0 asynchronously; the next download starts clean.

Source files
------------

// File: rtl/rom_load_arbiter_if.sv
// Memory port between rom_load_arbiter (master) and the core memory controller (slave).
// 16-bit word port with byte enables and a one-cycle ack.
interface rom_load_arbiter_if #(
  parameter int unsigned MEM_AW = 24
) ();
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter: packs the ioctl ROM byte stream into little-endian 16-bit writes and
// shares the memory port with a runtime read requester. Writes always win over reads.
// Optional: define ROM_LOAD_CHECKSUM_EN to build a 16-bit running sum of accepted bytes.
module rom_load_arbiter #(
  parameter int unsigned MEM_AW     = 24,
  parameter logic [7:0]  ROM_INDEX  = 8'h00,
  parameter int unsigned BASE_WADDR = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                ioctl_wait,
  input  logic                rd_req,
  input  logic [MEM_AW-1:0]   rd_addr,
  output logic [15:0]         rd_data,
  output logic                rd_ack,
  rom_load_arbiter_if.master  mem,
  output logic                load_busy,
  output logic                load_done,
  output logic                overrun,
  output logic [15:0]         checksum
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e            state_q, state_d;
  logic              dl_q, dl_d;
  logic              done_pend_q, done_pend_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        lo_q, lo_d;
  logic              lo_valid_q, lo_valid_d;
  logic [MEM_AW-1:0] lo_waddr_q, lo_waddr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [MEM_AW-1:0] wb_addr_q, wb_addr_d;
  logic [15:0]       wb_data_q, wb_data_d;
  logic [1:0]        wb_be_q, wb_be_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              rd_ack_q, rd_ack_d;

  logic              active, rise, fall, accept;
  logic [MEM_AW-1:0] byte_waddr;

  assign active     = ioctl_download && (ioctl_index == ROM_INDEX);
  assign rise       = active && !dl_q;
  assign fall       = dl_q && !ioctl_download;
  // A byte is only taken when the write buffer is empty (ioctl_wait low).
  assign accept     = active && ioctl_wr && !wb_valid_q;
  assign byte_waddr = MEM_AW'(ioctl_addr[24:1]) + MEM_AW'(BASE_WADDR);

  assign ioctl_wait = wb_valid_q;
  assign load_done  = done_pend_q && !wb_valid_q && !lo_valid_q;
  assign load_busy  = dl_q || (done_pend_q && !load_done);
  assign overrun    = overrun_q;
  assign rd_data    = rd_data_q;
  assign rd_ack     = rd_ack_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

  // Byte packing, write-buffer fill/drain, download edge tracking and overrun.
  always_comb begin
    dl_d        = active;
    done_pend_d = done_pend_q;
    overrun_d   = overrun_q;
    lo_d        = lo_q;
    lo_valid_d  = lo_valid_q;
    lo_waddr_d  = lo_waddr_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_be_d     = wb_be_q;
    if (rise) begin
      overrun_d   = 1'b0;
      done_pend_d = 1'b0;
    end
    if (state_q == StWrite && mem.mem_ack) wb_valid_d = 1'b0;
    if (active && ioctl_wr && wb_valid_q) overrun_d = 1'b1;
    if (accept) begin
      if (!ioctl_addr[0]) begin
        // A stale low byte without its partner goes out on its own first.
        if (lo_valid_q) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = lo_waddr_q;
          wb_data_d  = {8'h00, lo_q};
          wb_be_d    = 2'b01;
        end
        lo_d       = ioctl_dout;
        lo_valid_d = 1'b1;
        lo_waddr_d = byte_waddr;
      end else begin
        wb_valid_d = 1'b1;
        wb_addr_d  = byte_waddr;
        if (lo_valid_q && lo_waddr_q == byte_waddr) begin
          wb_data_d = {ioctl_dout, lo_q};
          wb_be_d   = 2'b11;
        end else begin
          wb_data_d = {ioctl_dout, 8'h00};
          wb_be_d   = 2'b10;
        end
        lo_valid_d = 1'b0;
      end
    end else if ((fall || done_pend_q) && lo_valid_q && !wb_valid_q) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = lo_waddr_q;
      wb_data_d  = {8'h00, lo_q};
      wb_be_d    = 2'b01;
      lo_valid_d = 1'b0;
    end
    if (load_done) done_pend_d = 1'b0;
    if (fall) done_pend_d = 1'b1;
  end

  // Pack and write-buffer state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      done_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      lo_q        <= '0;
      lo_valid_q  <= 1'b0;
      lo_waddr_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_be_q     <= '0;
    end else begin
      dl_q        <= dl_d;
      done_pend_q <= done_pend_d;
      overrun_q   <= overrun_d;
      lo_q        <= lo_d;
      lo_valid_q  <= lo_valid_d;
      lo_waddr_q  <= lo_waddr_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_be_q     <= wb_be_d;
    end
  end

  // Port arbitration FSM; the incoming buffer fill is seen so a same-cycle read loses.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rd_data_d   = rd_data_q;
    rd_ack_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wb_valid_d) begin
          state_d     = StWrite;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_addr_d;
          mem_wdata_d = wb_data_d;
          mem_be_d    = wb_be_d;
        end else if (rd_req && !rd_ack_q) begin
          // rd_req is still held in the rd_ack cycle; do not re-issue it.
          state_d    = StRead;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr;
          mem_be_d   = 2'b11;
        end
      end
      StWrite: begin
        if (mem.mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      StRead: begin
        if (mem.mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          rd_data_d = mem.mem_rdata;
          rd_ack_d  = 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // FSM and registered memory-port outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rd_data_q   <= '0;
      rd_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rd_data_q   <= rd_data_d;
      rd_ack_q    <= rd_ack_d;
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Wrapping sum of accepted bytes, restarted by each matching download.
  always_comb begin
    csum_d = csum_q;
    if (rise) csum_d = 16'h0000;
    if (accept) csum_d = csum_d + {8'h00, ioctl_dout};
  end

  // Checksum register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) csum_q <= 16'h0000;
    else          csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a simple memory responder and hand-computed
// expectations for packing, back-pressure, arbitration and reset behaviour.
module tb_rom_load_arbiter;

  localparam int unsigned MemAw = 24;
`ifdef ROM_LOAD_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } txn_t;

  logic             clk;
  logic             rst_n;
  logic             ioctl_download;
  logic [7:0]       ioctl_index;
  logic             ioctl_wr;
  logic [24:0]      ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic             ioctl_wait;
  logic             rd_req;
  logic [MemAw-1:0] rd_addr;
  logic [15:0]      rd_data;
  logic             rd_ack;
  logic             load_busy;
  logic             load_done;
  logic             overrun;
  logic [15:0]      checksum;

  rom_load_arbiter_if #(.MEM_AW(MemAw)) mem_if ();

  rom_load_arbiter #(
    .MEM_AW    (MemAw),
    .ROM_INDEX (8'h00),
    .BASE_WADDR(0)
  ) dut (
    .clock         (clk),
    .reset_n       (rst_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_ack        (rd_ack),
    .mem           (mem_if.master),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .overrun       (overrun),
    .checksum      (checksum)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   ack_delay = 2;
  int   wait_cnt = 0;
  int   last_ack_cyc = 0;
  logic [15:0] rd_val = 16'hBEEF;
  txn_t log_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks each request after ack_delay sampled cycles, logging it.
  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      if (!mem_if.mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = rd_val;
        log_q.push_back('{we: mem_if.mem_we, addr: mem_if.mem_addr,
                          data: mem_if.mem_wdata, be: mem_if.mem_be});
        last_ack_cyc = cyc;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while ((ioctl_wait || mem_if.mem_req) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " idle"}, {30'b0, ioctl_wait, mem_if.mem_req}, 32'd0);
  endtask

  task automatic wait_done(input string tag, output int at_cyc);
    int n = 0;
    while (!load_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    at_cyc = cyc;
    check_eq({tag, " load_done"}, {31'b0, load_done}, 32'd1);
    @(negedge clk);
    check_eq({tag, " load_done pulse"}, {31'b0, load_done}, 32'd0);
    check_eq({tag, " load_busy"}, {31'b0, load_busy}, 32'd0);
  endtask

  task automatic check_txn(input string tag, input int idx, input logic we,
                           input logic [23:0] addr, input logic [15:0] data,
                           input logic [1:0] be);
    if (log_q.size() > idx) begin
      check_eq({tag, " we"}, {31'b0, log_q[idx].we}, {31'b0, we});
      check_eq({tag, " addr"}, {8'b0, log_q[idx].addr}, {8'b0, addr});
      if (we) begin
        check_eq({tag, " data"}, {16'b0, log_q[idx].data}, {16'b0, data});
        check_eq({tag, " be"}, {30'b0, log_q[idx].be}, {30'b0, be});
      end
    end else begin
      check_eq({tag, " present"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    int dcyc;
    logic seen;
    logic [15:0] got_rd;
    rst_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    rd_req = 1'b0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("reset mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    check_eq("reset ioctl_wait", {31'b0, ioctl_wait}, 32'd0);
    check_eq("reset busy/done", {30'b0, load_busy, load_done}, 32'd0);
    check_eq("reset overrun/rd_ack", {30'b0, overrun, rd_ack}, 32'd0);
    check_eq("reset checksum", {16'b0, checksum}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four bytes, two full words.
    ack_delay = 2;
    log_q.delete();
    ioctl_download = 1'b1;
    @(negedge clk);
    check_eq("t1 busy", {31'b0, load_busy}, 32'd1);
    send_byte(25'd0, 8'h11); wait_ready("t1 b0");
    send_byte(25'd1, 8'h22); wait_ready("t1 b1");
    send_byte(25'd2, 8'h33); wait_ready("t1 b2");
    send_byte(25'd3, 8'h44); wait_ready("t1 b3");
    ioctl_download = 1'b0;
    wait_done("t1", dcyc);
    check_eq("t1 writes", log_q.size(), 32'd2);
    check_txn("t1 w0", 0, 1'b1, 24'd0, 16'h2211, 2'b11);
    check_txn("t1 w1", 1, 1'b1, 24'd1, 16'h4433, 2'b11);
    check_eq("t1 checksum", {16'b0, checksum}, CkEn ? 32'h00AA : 32'h0);

    // Lone odd byte, download falls while its write is still pending.
    log_q.delete();
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd7, 8'h5A);
    ioctl_download = 1'b0;
    wait_done("t2", dcyc);
    check_eq("t2 done after ack", dcyc - last_ack_cyc, 32'd1);
    check_eq("t2 writes", log_q.size(), 32'd1);
    check_txn("t2 w0", 0, 1'b1, 24'd3, 16'h5A00, 2'b10);

    // Lone even byte flushed at download end.
    log_q.delete();
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd4, 8'h77);
    ioctl_download = 1'b0;
    wait_done("t2b", dcyc);
    check_eq("t2b writes", log_q.size(), 32'd1);
    check_txn("t2b w0", 0, 1'b1, 24'd2, 16'h0077, 2'b01);

    // Byte strobed while ioctl_wait is high is dropped and flagged.
    ack_delay = 10;
    log_q.delete();
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd0, 8'hA1);
    send_byte(25'd1, 8'hB2);
    check_eq("t3 wait high", {31'b0, ioctl_wait}, 32'd1);
    send_byte(25'd2, 8'hC3);
    check_eq("t3 overrun", {31'b0, overrun}, 32'd1);
    wait_ready("t3");
    ioctl_download = 1'b0;
    wait_done("t3", dcyc);
    check_eq("t3 writes", log_q.size(), 32'd1);
    check_txn("t3 w0", 0, 1'b1, 24'd0, 16'hB2A1, 2'b11);
    check_eq("t3 overrun sticky", {31'b0, overrun}, 32'd1);
    check_eq("t3 checksum", {16'b0, checksum}, CkEn ? 32'h0153 : 32'h0);

    // Read requested in the cycle the buffer fills: write first, then read.
    ack_delay = 2;
    rd_val = 16'hBEEF;
    log_q.delete();
    ioctl_download = 1'b1;
    @(negedge clk);
    check_eq("t4 overrun cleared", {31'b0, overrun}, 32'd0);
    send_byte(25'd10, 8'h01);
    rd_req  = 1'b1;
    rd_addr = 24'h000123;
    send_byte(25'd11, 8'h02);
    seen = 1'b0;
    got_rd = 16'h0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (rd_ack) begin
        seen = 1'b1;
        got_rd = rd_data;
      end else begin
        @(negedge clk);
      end
    end
    rd_req = 1'b0;
    check_eq("t4 rd_ack", {31'b0, seen}, 32'd1);
    check_eq("t4 rd_data", {16'b0, got_rd}, 32'h0000BEEF);
    @(negedge clk);
    check_eq("t4 rd_ack pulse", {31'b0, rd_ack}, 32'd0);
    repeat (4) @(negedge clk);
    check_eq("t4 txns", log_q.size(), 32'd2);
    check_txn("t4 w0", 0, 1'b1, 24'd5, 16'h0201, 2'b11);
    check_txn("t4 r1", 1, 1'b0, 24'h000123, 16'h0, 2'b00);
    ioctl_download = 1'b0;
    wait_done("t4", dcyc);

    // Non-matching index: no stall, no memory traffic.
    log_q.delete();
    ioctl_index = 8'h01;
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd0, 8'h99);
    send_byte(25'd1, 8'h88);
    check_eq("t5 wait", {31'b0, ioctl_wait}, 32'd0);
    check_eq("t5 busy", {31'b0, load_busy}, 32'd0);
    seen = 1'b0;
    ioctl_download = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | load_done | mem_if.mem_req;
    end
    check_eq("t5 quiet", {31'b0, seen}, 32'd0);
    check_eq("t5 txns", log_q.size(), 32'd0);
    ioctl_index = 8'h00;

    // Reset during an outstanding write.
    ack_delay = 10;
    log_q.delete();
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd0, 8'h55);
    send_byte(25'd1, 8'h66);
    for (int n = 0; n < 20 && !mem_if.mem_req; n++) @(negedge clk);
    check_eq("t6 req before reset", {31'b0, mem_if.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6 async mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    check_eq("t6 async wait", {31'b0, ioctl_wait}, 32'd0);
    check_eq("t6 async busy", {31'b0, load_busy}, 32'd0);
    @(negedge clk);
    ioctl_download = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_delay = 2;
    log_q.delete();
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd0, 8'h11); wait_ready("t6 b0");
    send_byte(25'd1, 8'h22); wait_ready("t6 b1");
    ioctl_download = 1'b0;
    wait_done("t6", dcyc);
    check_eq("t6 writes", log_q.size(), 32'd1);
    check_txn("t6 w0", 0, 1'b1, 24'd0, 16'h2211, 2'b11);
    check_eq("t6 overrun", {31'b0, overrun}, 32'd0);
    check_eq("t6 checksum", {16'b0, checksum}, CkEn ? 32'h0033 : 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog in case a wait above never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
